// File: rtl/fifo_slave_pkg.sv
// Shared constants for the fifo_slave bus FIFO.
// Register addresses and FLAG bit positions.
package fifo_slave_pkg;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_FLAG   = 8'h01;
  localparam logic [7:0] ADDR_COUNT  = 8'h02;
  localparam logic [7:0] ADDR_CLEAR  = 8'h03;
  localparam logic [7:0] ADDR_THRESH = 8'h04;
  localparam logic [7:0] ADDR_IRQEN  = 8'h05;

  localparam int FLG_FULL   = 5;
  localparam int FLG_EMPTY  = 4;
  localparam int FLG_AFULL  = 3;
  localparam int FLG_AEMPTY = 2;
  localparam int FLG_WERR   = 1;
  localparam int FLG_RERR   = 0;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DW storage: sync write, async read, no reset.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module fifo_ram
  import fifo_slave_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_slave.sv
// Bus-slave FIFO with DATA/FLAG/COUNT/CLEAR registers.
// Ports: clk, reset, S_sel, S_wr, S_address, S_din, S_dout
// (+ fifo_irq, THRESH, IRQ_EN when FIFO_SLAVE_IRQ_EN).
module fifo_slave
  import fifo_slave_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          S_sel,
  input  logic          S_wr,
  input  logic [7:0]    S_address,
  input  logic [DW-1:0] S_din,
`ifdef FIFO_SLAVE_IRQ_EN
  output logic          fifo_irq,
`endif
  output logic [DW-1:0] S_dout
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = FULL_CNT - 1'b1;
  localparam logic [AW:0] ONE_CNT = (AW+1)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_err;
  logic          rd_err;
  logic          full;
  logic          empty;
  logic          push;
  logic [DW-1:0] rdata;
  logic [DW-1:0] flag_word;
`ifdef FIFO_SLAVE_IRQ_EN
  logic [AW:0]   thresh;
  logic          irq_en;
`endif

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = S_sel && S_wr &&
                 (S_address == ADDR_DATA) && !full;

  always_comb begin
    flag_word             = '0;
    flag_word[FLG_FULL]   = full;
    flag_word[FLG_EMPTY]  = empty;
    flag_word[FLG_AFULL]  = (count == AFULL_CNT);
    flag_word[FLG_AEMPTY] = (count == ONE_CNT);
    flag_word[FLG_WERR]   = wr_err;
    flag_word[FLG_RERR]   = rd_err;
  end

  fifo_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(S_din),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
      S_dout <= '0;
`ifdef FIFO_SLAVE_IRQ_EN
      thresh   <= ONE_CNT;
      irq_en   <= 1'b0;
      fifo_irq <= 1'b0;
`endif
    end else begin
`ifdef FIFO_SLAVE_IRQ_EN
      fifo_irq <= irq_en && (count >= thresh);
`endif
      if (S_sel && S_wr) begin
        unique case (1'b1)
          (S_address == ADDR_DATA): begin
            if (!full) begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count + 1'b1;
            end else begin
              wr_err <= 1'b1;
            end
          end
          (S_address == ADDR_CLEAR): begin
            if (S_din[0]) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              count  <= '0;
              wr_err <= 1'b0;
              rd_err <= 1'b0;
            end
          end
`ifdef FIFO_SLAVE_IRQ_EN
          (S_address == ADDR_THRESH):
            thresh <= S_din[AW:0];
          (S_address == ADDR_IRQEN):
            irq_en <= S_din[0];
`endif
          default: ;
        endcase
      end else if (S_sel) begin
        unique case (1'b1)
          (S_address == ADDR_DATA): begin
            if (!empty) begin
              S_dout <= rdata;
              rd_ptr <= rd_ptr + 1'b1;
              count  <= count - 1'b1;
            end else begin
              S_dout <= '0;
              rd_err <= 1'b1;
            end
          end
          (S_address == ADDR_FLAG):
            S_dout <= flag_word;
          (S_address == ADDR_COUNT):
            S_dout <= DW'(count);
`ifdef FIFO_SLAVE_IRQ_EN
          (S_address == ADDR_THRESH):
            S_dout <= DW'(thresh);
          (S_address == ADDR_IRQEN):
            S_dout <= DW'(irq_en);
`endif
          default:
            S_dout <= '0;
        endcase
      end
    end
  end

endmodule

// File: doc/fifo_slave.md
Name: fifo_slave

Overview:
- Bus-slave FIFO that buffers 32-bit words between the system bus and the factorial engine's master port.
- The host pushes N values; the factorial master polls the flag register, pops operands, and pushes result words back, all over the same slave bus.
- Flag encoding matches the engine's CHECK_FLAG decode: 6'b100000 = full, 6'b010000 = empty.

Parameters:
- DEPTH, 16, number of 32-bit entries; must be a power of two, at least 4.
- AW, 4, pointer width; must equal log2(DEPTH).
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- S_sel  input  1  slave select.
- S_wr  input  1  1 = write, 0 = read; valid only while S_sel = 1.
- S_address  input  8  register address.
- S_din  input  DW  write data.
- S_dout  output  DW  registered read data.

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - S_dout = 0.
  - Sticky error bits cleared.
  - Reset dominates any bus access in the same cycle.
  - Reset mid-transfer discards all contents.
- Address map:
  - 0x00 DATA: write = push, read = pop.
  - 0x01 FLAG (read-only): bit5 full, bit4 empty, bit3 almost_full (count == DEPTH-1), bit2 almost_empty (count == 1), bit1 wr_err, bit0 rd_err; bits 31:6 = 0.
  - 0x02 COUNT (read-only): zero-extended count, width AW+1.
  - 0x03 CLEAR (write-only): S_din[0] = 1 resets pointers, count and error bits; the RAM is not cleared.
  - Any other address: reads return 0, writes are ignored.
- Write, push: S_sel && S_wr && address 0x00 && !full.
  - mem[wr_ptr] <= S_din; wr_ptr increments (wraps modulo DEPTH); count increments.
- Write when full: data is dropped, wr_err is set, pointers are unchanged.
- Read, pop: S_sel && !S_wr && address 0x00 && !empty.
  - S_dout <= mem[rd_ptr] on that edge, so data is valid from the next cycle (1-cycle latency).
  - rd_ptr increments (wraps modulo DEPTH); count decrements.
- Read when empty: S_dout <= 0, rd_err is set, pointers are unchanged.
- Reads of FLAG and COUNT: registered with the same 1-cycle latency; they reflect pre-edge state.
- S_dout holds its last value while S_sel = 0.
- No simultaneous push and pop is possible: there is a single bus port.
- Error bits are sticky until CLEAR or reset.
- full = (count == DEPTH); empty = (count == 0).
- Pointer wrap: a DEPTH+1 push/pop sequence must return data in order across the wrap.

Optional Feature:
- Macro: FIFO_SLAVE_IRQ_EN.
- When defined:
  - Adds port fifo_irq (output, 1 bit, registered).
  - Adds THRESH register at 0x04: read/write, AW+1 bits, reset value 1.
  - Adds IRQ_EN register at 0x05: bit0, reset value 0.
  - fifo_irq = IRQ_EN[0] && (count >= THRESH), updated one cycle after count changes.
- When undefined:
  - Port fifo_irq is absent.
  - Addresses 0x04 and 0x05 behave as unmapped.

Decomposition:
- Package fifo_slave_pkg holds:
  - Address constants ADDR_DATA, ADDR_FLAG, ADDR_COUNT, ADDR_CLEAR, ADDR_THRESH, ADDR_IRQEN.
  - Flag bit indices FLG_FULL = 5, FLG_EMPTY = 4, FLG_AFULL = 3, FLG_AEMPTY = 2, FLG_WERR = 1, FLG_RERR = 0.
- Sub-module fifo_ram:
  - DEPTH x DW register array, synchronous write, asynchronous read.
  - No reset on contents.
  - Pointers, count and bus decode stay in fifo_slave.

Test Plan:
- Reset, then read FLAG -> S_dout = 32'h10 next cycle; COUNT reads 0.
- Push 10, read FLAG -> 32'h04 (almost_empty); pop -> S_dout = 10 one cycle later; FLAG then reads 32'h10.
- Push 16 words 1..16 -> FLAG = 32'h20; 17th push (99) is dropped, FLAG = 32'h22; pop 16 -> 1..16 in order.
- Pop when empty -> S_dout = 0, FLAG = 32'h11; write 1 to 0x03 -> FLAG = 32'h10.
- Wrap: push 12 / pop 12, then push 8 / pop 8 -> data in order, COUNT = 0 at the end; assert reset mid-sequence -> COUNT = 0 on the next read.
- With FIFO_SLAVE_IRQ_EN: THRESH = 3, IRQ_EN = 1, push 3 -> fifo_irq = 1 on the cycle after the 3rd push; one pop -> fifo_irq = 0.
